// File: rtl/program_memory_if.sv
// Processor memory bus, loader port and control/status signals for program_memory.
// The master side is the processor/host; the slave side is the memory.
interface program_memory_if #(
  parameter int word_size = 8,
  parameter int addr_size = 8
);
  logic [addr_size-1:0] address;
  logic [word_size-1:0] data_in;
  logic                 write;
  logic [word_size-1:0] data_out;
  logic                 cpu_rst;
  logic                 ld_start;
  logic [addr_size-1:0] ld_base;
  logic [addr_size-1:0] ld_count;
  logic                 ld_valid;
  logic [word_size-1:0] ld_data;
  logic                 ld_ready;
  logic                 ld_done;
  logic                 go;
  logic                 busy;
  logic [word_size-1:0] checksum;
  logic                 wr_err;

  modport master (
    output address, data_in, write, ld_start, ld_base, ld_count,
           ld_valid, ld_data, go,
    input  data_out, cpu_rst, ld_ready, ld_done, busy, checksum, wr_err
  );

  modport slave (
    input  address, data_in, write, ld_start, ld_base, ld_count,
           ld_valid, ld_data, go,
    output data_out, cpu_rst, ld_ready, ld_done, busy, checksum, wr_err
  );
endinterface

// File: rtl/program_memory.sv
// Unified program/data memory that also sequences the processor reset:
// clear after reset, byte-load over valid/ready, then release on go.
//
// state  | meaning
// S_clr  | zeroing memory one word per cycle, processor held in reset
// S_hold | idle, processor held in reset, waiting for ld_start or go
// S_load | accepting loader bytes, processor held in reset
// S_run  | processor released, owns the memory write port
module program_memory #(
  parameter int word_size = 8,
  parameter int addr_size = 8,
  parameter int mem_depth = 256
) (
  input logic              clk,
  input logic              rst,
  program_memory_if.slave  bus
);

  typedef enum logic [1:0] {
    S_clr  = 2'd0,
    S_hold = 2'd1,
    S_load = 2'd2,
    S_run  = 2'd3
  } state_t;

  localparam logic [addr_size-1:0] LAST_ADDR = addr_size'(mem_depth - 1);
  localparam logic [addr_size-1:0] ONE       = addr_size'(1);

  state_t               r_state;
  logic [addr_size-1:0] r_clr_cnt;
  logic [addr_size-1:0] r_ld_ptr;
  logic [addr_size-1:0] r_ld_rem;
  logic [word_size-1:0] r_checksum;
  logic                 r_ld_done;
  logic                 r_wr_err;
  logic [word_size-1:0] r_mem [mem_depth];

  logic                 w_we;
  logic [addr_size-1:0] w_waddr;
  logic [word_size-1:0] w_wdata;

  // Single write port, owner selected by state.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = bus.address;
    w_wdata = bus.data_in;
    case (r_state)
      S_clr: begin
        w_we    = 1'b1;
        w_waddr = r_clr_cnt;
        w_wdata = '0;
      end
      S_load: begin
        w_we    = bus.ld_valid;
        w_waddr = r_ld_ptr;
        w_wdata = bus.ld_data;
      end
      S_run: begin
        w_we    = bus.write;
        w_waddr = bus.address;
        w_wdata = bus.data_in;
      end
      default: w_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_clr;
      r_clr_cnt  <= '0;
      r_ld_ptr   <= '0;
      r_ld_rem   <= '0;
      r_checksum <= '0;
      r_ld_done  <= 1'b0;
      r_wr_err   <= 1'b0;
    end else begin
      r_ld_done <= 1'b0;
      // Clearing ignores every input, so a stray write there is not flagged.
      r_wr_err  <= bus.write && (r_state == S_hold || r_state == S_load);
      case (r_state)
        S_clr: begin
          r_clr_cnt <= r_clr_cnt + ONE;
          if (r_clr_cnt == LAST_ADDR) r_state <= S_hold;
        end
        S_hold, S_run: begin
          if (bus.ld_start) begin
            r_checksum <= '0;
            if (bus.ld_count != '0) begin
              r_ld_ptr <= bus.ld_base;
              r_ld_rem <= bus.ld_count;
              r_state  <= S_load;
            end else begin
              r_ld_done <= 1'b1;
              r_state   <= S_hold;
            end
          end else if (bus.go && r_state == S_hold) begin
            r_state <= S_run;
          end
        end
        S_load: begin
          if (bus.ld_valid) begin
            r_mem_accept : begin
              r_ld_ptr   <= r_ld_ptr + ONE;
              r_ld_rem   <= r_ld_rem - ONE;
              r_checksum <= r_checksum + bus.ld_data;
              if (r_ld_rem == ONE) begin
                r_state   <= S_hold;
                r_ld_done <= 1'b1;
              end
            end
          end
        end
        default: r_state <= S_clr;
      endcase
    end
  end

  assign bus.data_out = r_mem[bus.address];
  assign bus.cpu_rst  = (r_state == S_run);
  assign bus.ld_ready = (r_state == S_load);
  assign bus.busy     = (r_state == S_clr) || (r_state == S_load);
  assign bus.checksum = r_checksum;
  assign bus.ld_done  = r_ld_done;
  assign bus.wr_err   = r_wr_err;

endmodule

// File: tb/tb_program_memory.sv
// Self-checking bench for program_memory: clear timing, loads with a
// scoreboard of expected memory bytes, a table of processor accesses, resets.
module tb_program_memory;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  program_memory_if bus ();

  program_memory dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_sb();
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      bus.address = e.addr;
      #1;
      chk($sformatf("mem[%0h]", e.addr), bus.data_out, e.data);
    end
  endtask

  task automatic wait_clear(input string name);
    int n;
    bit seen_cpu;
    n = 0;
    seen_cpu = 0;
    while (n < 400) begin
      tick();
      n++;
      if (bus.cpu_rst) seen_cpu = 1;
      if (!bus.busy) break;
    end
    chk({name, "_cycles"}, n, 256);
    chk({name, "_cpu_rst_held"}, seen_cpu, 0);
  endtask

  task automatic start_load(input logic [7:0] base, input logic [7:0] cnt, input logic with_go);
    bus.ld_start = 1'b1;
    bus.ld_base  = base;
    bus.ld_count = cnt;
    bus.go       = with_go;
    tick();
    bus.ld_start = 1'b0;
    bus.go       = 1'b0;
  endtask

  initial begin
    logic [7:0] ptr;
    logic [7:0] sum;

    vecs[0] = '{1'b1, 8'h20, 8'hC3, 8'h00};
    vecs[1] = '{1'b0, 8'h20, 8'h00, 8'hC3};
    vecs[2] = '{1'b1, 8'h21, 8'h5A, 8'h00};
    vecs[3] = '{1'b1, 8'h20, 8'h3C, 8'hC3};
    vecs[4] = '{1'b0, 8'h21, 8'h00, 8'h5A};
    vecs[5] = '{1'b0, 8'h20, 8'h00, 8'h3C};
    vecs[6] = '{1'b0, 8'h10, 8'h00, 8'h51};
    vecs[7] = '{1'b0, 8'hFF, 8'h00, 8'hA2};
    vecs[8] = '{1'b0, 8'h00, 8'h00, 8'hA4};

    bus.address  = '0;
    bus.data_in  = '0;
    bus.write    = 1'b0;
    bus.ld_start = 1'b0;
    bus.ld_base  = '0;
    bus.ld_count = '0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    bus.go       = 1'b0;

    // Reset state.
    repeat (3) tick();
    chk("rst_busy", bus.busy, 1);
    chk("rst_cpu_rst", bus.cpu_rst, 0);
    chk("rst_ld_ready", bus.ld_ready, 0);
    chk("rst_ld_done", bus.ld_done, 0);
    chk("rst_wr_err", bus.wr_err, 0);
    chk("rst_checksum", bus.checksum, 0);

    rst = 1'b1;
    wait_clear("clear");
    foreach (vecs[i]) begin end
    sb_q.push_back('{8'h00, 8'h00});
    sb_q.push_back('{8'h7F, 8'h00});
    sb_q.push_back('{8'hFF, 8'h00});
    drain_sb();

    // Load 3 bytes at 0x10 with ld_valid held.
    start_load(8'h10, 8'd3, 1'b0);
    chk("load1_ready", bus.ld_ready, 1);
    chk("load1_busy", bus.busy, 1);
    ptr = 8'h10;
    foreach (sb_q[i]) begin end
    for (int i = 0; i < 3; i++) begin
      logic [7:0] b;
      b = (i == 0) ? 8'h51 : (i == 1) ? 8'h2A : 8'h0F;
      bus.ld_valid = 1'b1;
      bus.ld_data  = b;
      sb_q.push_back('{ptr, b});
      ptr++;
      tick();
    end
    bus.ld_valid = 1'b0;
    chk("load1_done", bus.ld_done, 1);
    chk("load1_ready_off", bus.ld_ready, 0);
    chk("load1_checksum", bus.checksum, 8'h8A);
    tick();
    chk("load1_done_pulse", bus.ld_done, 0);
    drain_sb();

    // Wrapping load with ld_valid toggled; then one extra valid byte must not land.
    start_load(8'hFE, 8'd4, 1'b0);
    ptr = 8'hFE;
    sum = 8'h00;
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("load2_ready_%0d", i), bus.ld_ready, 1);
      bus.ld_valid = (i % 2 == 0);
      bus.ld_data  = 8'hA0 + 8'(i);
      if (bus.ld_valid) begin
        sb_q.push_back('{ptr, bus.ld_data});
        sum = sum + bus.ld_data;
        ptr++;
      end
      tick();
    end
    chk("load2_ready_off", bus.ld_ready, 0);
    chk("load2_done", bus.ld_done, 1);
    chk("load2_checksum", bus.checksum, sum);
    bus.ld_valid = 1'b1;
    bus.ld_data  = 8'hEE;
    tick();
    bus.ld_valid = 1'b0;
    sb_q.push_back('{8'h02, 8'h00});
    drain_sb();

    // Processor write while held in reset is dropped and flagged.
    bus.address = 8'h20;
    bus.data_in = 8'h55;
    bus.write   = 1'b1;
    tick();
    bus.write   = 1'b0;
    chk("hold_wr_err", bus.wr_err, 1);
    chk("hold_mem20", bus.data_out, 8'h00);
    tick();
    chk("hold_wr_err_pulse", bus.wr_err, 0);

    // Release processor.
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    chk("go_cpu_rst", bus.cpu_rst, 1);
    chk("go_busy", bus.busy, 0);

    for (int i = 0; i < 9; i++) begin
      bus.address = vecs[i].addr;
      bus.data_in = vecs[i].wdata;
      bus.write   = vecs[i].wr;
      #1;
      chk($sformatf("run_vec%0d", i), bus.data_out, vecs[i].exp);
      tick();
      chk($sformatf("run_vec%0d_wr_err", i), bus.wr_err, 0);
    end
    bus.write = 1'b0;

    // Load from S_run drops cpu_rst at the start edge.
    start_load(8'h40, 8'd2, 1'b0);
    chk("runload_cpu_rst", bus.cpu_rst, 0);
    chk("runload_ready", bus.ld_ready, 1);
    bus.ld_valid = 1'b1;
    bus.ld_data  = 8'h11;
    sb_q.push_back('{8'h40, 8'h11});
    tick();
    bus.ld_data  = 8'h22;
    sb_q.push_back('{8'h41, 8'h22});
    tick();
    bus.ld_valid = 1'b0;
    chk("runload_done", bus.ld_done, 1);
    chk("runload_checksum", bus.checksum, 8'h33);
    chk("runload_cpu_rst_after", bus.cpu_rst, 0);
    drain_sb();

    // Zero-count load: done pulse, checksum cleared, stays held.
    start_load(8'h00, 8'd0, 1'b0);
    chk("zero_done", bus.ld_done, 1);
    chk("zero_checksum", bus.checksum, 0);
    chk("zero_ready", bus.ld_ready, 0);

    // ld_start and go together: load wins.
    start_load(8'h80, 8'd3, 1'b1);
    chk("startgo_ready", bus.ld_ready, 1);
    chk("startgo_cpu_rst", bus.cpu_rst, 0);
    bus.ld_valid = 1'b1;
    bus.ld_data  = 8'h77;
    tick();
    bus.ld_valid = 1'b0;
    bus.address  = 8'h80;
    #1;
    chk("partial_byte", bus.data_out, 8'h77);

    // Reset mid-load.
    rst = 1'b0;
    #1;
    chk("midrst_busy", bus.busy, 1);
    chk("midrst_ready", bus.ld_ready, 0);
    chk("midrst_cpu_rst", bus.cpu_rst, 0);
    tick();
    rst = 1'b1;
    wait_clear("reclear");
    sb_q.push_back('{8'h80, 8'h00});
    sb_q.push_back('{8'h20, 8'h00});
    sb_q.push_back('{8'h10, 8'h00});
    drain_sb();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
